// File: rtl/if_stage_pkg.sv
// Shared types for the fetch path: pre-IF/IF/ID bundles,
// exception record and the pipeline flush vector.
package if_stage_pkg;

  typedef logic [31:0] virt_t;

  localparam logic [4:0] EXC_ADEL = 5'h04;

  typedef struct packed {
    logic       ex;
    logic [4:0] exccode;
    logic       refill;
    logic       bd;
    virt_t      badvaddr;
  } exception_t;

  typedef struct packed {
    logic       valid;
    logic       addr_acked;
    logic       br_op;
    virt_t      pc;
    exception_t exception;
  } pfs_to_fs_bus_t;

  typedef struct packed {
    virt_t       pc;
    logic [31:0] inst;
    logic        br_op;
    exception_t  exception;
  } fs_to_ds_bus_t;

  typedef struct packed {
    logic ex;
    logic eret;
    logic tlb_op;
    logic tlb_refill;
  } pipeline_flush_t;

  // tlb_refill only qualifies a tlb exception; it never flushes alone
  function automatic logic FLUSH_ANY(input pipeline_flush_t f);
    pipeline_flush_t m;
    m = f;
    m.tlb_refill = 1'b0;
    return |m;
  endfunction

endpackage

// File: rtl/if_inst_buffer.sv
// One-entry instruction hold register for IF, with the
// buffered/pass-through select mux.
module if_inst_buffer
  import if_stage_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        load,
  input  logic        clear,
  input  logic        zero,
  input  logic [31:0] rdata,
  output logic        buf_valid,
  output logic [31:0] inst
);

  logic [31:0] inst_buf;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      buf_valid <= 1'b0;
      inst_buf  <= '0;
    end else if (clear) begin
      buf_valid <= 1'b0;
    end else if (load) begin
      buf_valid <= 1'b1;
      inst_buf  <= rdata;
    end
  end

  assign inst = zero      ? 32'h0 :
                buf_valid ? inst_buf : rdata;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: waits for inst_sram data, holds it
// while ID stalls, and drops responses owned by flushed fetches.
module if_stage
  import if_stage_pkg::*;
#(
  parameter int DISCARD_W = 2
) (
  input  logic            clk,
  input  logic            resetn,
  input  pfs_to_fs_bus_t  pfs_to_fs_bus,
  output logic            fs_allowin,
  output logic            fs_valid,
  input  logic            ds_allowin,
  output logic            fs_to_ds_valid,
  output fs_to_ds_bus_t   fs_to_ds_bus,
  input  pipeline_flush_t pipeline_flush,
  input  logic            inst_data_ok,
  input  logic [31:0]     inst_rdata
);

  localparam int CW = DISCARD_W + 1;

  virt_t          pc_q;
  logic           br_op_q;
  exception_t     exc_q;
  logic           req_pending;
  logic [DISCARD_W-1:0] discard_cnt;
  logic [CW-1:0]  cnt_sum;

  logic flush, stale, rsp_ok, fs_ready_go;
  logic accept, latch, buf_load, buf_valid;
  logic inc_own, inc_pfs, dec;
  logic [31:0] inst;

  assign flush  = FLUSH_ANY(pipeline_flush);
  assign stale  = |discard_cnt;
  assign rsp_ok = req_pending & inst_data_ok & ~stale;

  assign fs_ready_go    = exc_q.ex | buf_valid | rsp_ok;
  assign fs_allowin     = ~fs_valid | (fs_ready_go & ds_allowin);
  assign fs_to_ds_valid = fs_valid & fs_ready_go & ~flush;

  assign accept   = fs_to_ds_valid & ds_allowin;
  assign latch    = fs_allowin & pfs_to_fs_bus.valid & ~flush;
  assign buf_load = fs_valid & rsp_ok & ~ds_allowin & ~flush;

  // responses still owed by the bus that nobody will claim
  assign inc_own = flush & fs_valid & req_pending
                 & ~(inst_data_ok & ~stale);
  assign inc_pfs = flush & pfs_to_fs_bus.addr_acked;
  assign dec     = inst_data_ok & stale;
  assign cnt_sum = CW'(discard_cnt) + CW'(inc_own)
                 + CW'(inc_pfs) - CW'(dec);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      fs_valid    <= 1'b0;
      req_pending <= 1'b0;
      discard_cnt <= '0;
      pc_q        <= '0;
      br_op_q     <= 1'b0;
      exc_q       <= '0;
    end else begin
      discard_cnt <= cnt_sum[DISCARD_W-1:0];
      if (flush) begin
        fs_valid    <= 1'b0;
        req_pending <= 1'b0;
      end else if (latch) begin
        fs_valid    <= 1'b1;
        req_pending <= pfs_to_fs_bus.addr_acked;
        pc_q        <= pfs_to_fs_bus.pc;
        br_op_q     <= pfs_to_fs_bus.br_op;
        exc_q       <= pfs_to_fs_bus.exception;
      end else if (accept) begin
        fs_valid    <= 1'b0;
        req_pending <= 1'b0;
      end else if (buf_load) begin
        req_pending <= 1'b0;
      end
    end
  end

  if_inst_buffer u_buf (
    .clk       (clk),
    .resetn    (resetn),
    .load      (buf_load),
    .clear     (flush | accept),
    .zero      (exc_q.ex),
    .rdata     (inst_rdata),
    .buf_valid (buf_valid),
    .inst      (inst)
  );

  assign fs_to_ds_bus = '{
    pc:        pc_q,
    inst:      inst,
    br_op:     br_op_q,
    exception: exc_q
  };

  a_no_orphan_rsp: assert property (
    @(posedge clk) disable iff (!resetn)
    !(inst_data_ok && !stale && !req_pending));

  a_discard_ovf: assert property (
    @(posedge clk) disable iff (!resetn)
    !cnt_sum[DISCARD_W]);

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed vector table, reset-in-stall
// sequence, then random traffic against a response-queue model.
module tb_if_stage;
  import if_stage_pkg::*;

  logic            clk;
  logic            resetn;
  pfs_to_fs_bus_t  pfs;
  logic            fs_allowin;
  logic            fs_valid;
  logic            ds_allowin;
  logic            fs_to_ds_valid;
  fs_to_ds_bus_t   fs_to_ds_bus;
  pipeline_flush_t pfl;
  logic            inst_data_ok;
  logic [31:0]     inst_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  if_stage #(.DISCARD_W(2)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .pfs_to_fs_bus  (pfs),
    .fs_allowin     (fs_allowin),
    .fs_valid       (fs_valid),
    .ds_allowin     (ds_allowin),
    .fs_to_ds_valid (fs_to_ds_valid),
    .fs_to_ds_bus   (fs_to_ds_bus),
    .pipeline_flush (pfl),
    .inst_data_ok   (inst_data_ok),
    .inst_rdata     (inst_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic exception_t adel(input logic [31:0] va);
    exception_t e;
    e = '0;
    e.ex = 1'b1;
    e.exccode = EXC_ADEL;
    e.badvaddr = va;
    return e;
  endfunction

  // ctl = {pv, ack, ex, flush, ds_allowin, data_ok}
  task automatic drive(input logic [5:0] ctl, input logic [31:0] pc,
                       input logic [31:0] rd);
    pfs = '0;
    pfs.valid = ctl[5];
    pfs.addr_acked = ctl[4];
    pfs.pc = pc;
    pfs.br_op = pc[2];
    if (ctl[3]) pfs.exception = adel(pc);
    pfl = '0;
    pfl.ex = ctl[2];
    ds_allowin = ctl[1];
    inst_data_ok = ctl[0];
    inst_rdata = rd;
  endtask

  // exp = {fs_allowin, fs_valid, fs_to_ds_valid, exception}
  typedef struct {
    logic [5:0]  ctl;
    logic [31:0] pc;
    logic [31:0] rd;
    logic [3:0]  exp;
    logic [31:0] einst;
    logic [31:0] epc;
  } vec_t;

  vec_t tbl[20];

  // behavioural model: in-order queue of outstanding responses,
  // 1 = belongs to the live instruction, 0 = orphaned by a flush
  bit              q[$];
  bit              live, have, pend, f, arrive, ready, e_allow, e_out;
  logic [31:0]     m_inst;
  pfs_to_fs_bus_t  m_pkt, rpkt;
  fs_to_ds_bus_t   e_bus;
  int              junk;

  initial begin
    tbl[0]  = '{6'b110010, 32'hbfc00000, 32'h0, 4'b1000, 32'h0, 32'h0};
    tbl[1]  = '{6'b000011, 32'h0, 32'h24080001, 4'b1110, 32'h24080001, 32'hbfc00000};
    tbl[2]  = '{6'b110000, 32'hbfc00004, 32'h0, 4'b1000, 32'h0, 32'h0};
    tbl[3]  = '{6'b000001, 32'h0, 32'h8c090004, 4'b0110, 32'h8c090004, 32'hbfc00004};
    tbl[4]  = '{6'b000000, 32'h0, 32'h0, 4'b0110, 32'h8c090004, 32'hbfc00004};
    tbl[5]  = '{6'b000000, 32'h0, 32'h11111111, 4'b0110, 32'h8c090004, 32'hbfc00004};
    tbl[6]  = '{6'b000010, 32'h0, 32'h22222222, 4'b1110, 32'h8c090004, 32'hbfc00004};
    tbl[7]  = '{6'b000010, 32'h0, 32'h0, 4'b1000, 32'h0, 32'h0};
    tbl[8]  = '{6'b110010, 32'hbfc00008, 32'h0, 4'b1000, 32'h0, 32'h0};
    tbl[9]  = '{6'b110110, 32'hbfc0000c, 32'h0, 4'b0100, 32'h0, 32'h0};
    tbl[10] = '{6'b110011, 32'hbfc00380, 32'hdead0001, 4'b1000, 32'h0, 32'h0};
    tbl[11] = '{6'b000011, 32'h0, 32'hdead0002, 4'b0100, 32'h0, 32'h0};
    tbl[12] = '{6'b000011, 32'h0, 32'h00000000, 4'b1110, 32'h0, 32'hbfc00380};
    tbl[13] = '{6'b101010, 32'hbfc00002, 32'h0, 4'b1000, 32'h0, 32'h0};
    tbl[14] = '{6'b000010, 32'h0, 32'h33333333, 4'b1111, 32'h0, 32'hbfc00002};
    tbl[15] = '{6'b110010, 32'hbfc00010, 32'h0, 4'b1000, 32'h0, 32'h0};
    tbl[16] = '{6'b000111, 32'h0, 32'h44444444, 4'b1100, 32'h0, 32'h0};
    tbl[17] = '{6'b110010, 32'hbfc00014, 32'h0, 4'b1000, 32'h0, 32'h0};
    tbl[18] = '{6'b000011, 32'h0, 32'h55555555, 4'b1110, 32'h55555555, 32'hbfc00014};
    tbl[19] = '{6'b000010, 32'h0, 32'h0, 4'b1000, 32'h0, 32'h0};

    resetn = 1'b0;
    drive(6'b0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_allowin", 128'(fs_allowin), 128'(1'b1));
    chk("rst_fs_valid", 128'(fs_valid), 128'(1'b0));
    chk("rst_to_ds_valid", 128'(fs_to_ds_valid), 128'(1'b0));
    resetn = 1'b1;

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      drive(tbl[i].ctl, tbl[i].pc, tbl[i].rd);
      #1;
      chk($sformatf("t%0d_allowin", i), 128'(fs_allowin), 128'(tbl[i].exp[3]));
      chk($sformatf("t%0d_fs_valid", i), 128'(fs_valid), 128'(tbl[i].exp[2]));
      chk($sformatf("t%0d_to_ds_valid", i), 128'(fs_to_ds_valid),
          128'(tbl[i].exp[1]));
      if (tbl[i].exp[1]) begin
        e_bus = '{pc: tbl[i].epc, inst: tbl[i].einst, br_op: tbl[i].epc[2],
                  exception: tbl[i].exp[0] ? adel(tbl[i].epc) : '0};
        chk($sformatf("t%0d_bus", i), 128'(fs_to_ds_bus), 128'(e_bus));
      end
    end

    // reset while an instruction sits in the hold buffer
    @(negedge clk);
    drive(6'b110000, 32'hbfc00020, 32'h0);
    @(negedge clk);
    drive(6'b000001, 32'h0, 32'h66666666);
    @(negedge clk);
    drive(6'b000000, 32'h0, 32'h0);
    #1;
    chk("stall_to_ds_valid", 128'(fs_to_ds_valid), 128'(1'b1));
    chk("stall_inst", 128'(fs_to_ds_bus.inst), 128'(32'h66666666));
    chk("stall_allowin", 128'(fs_allowin), 128'(1'b0));
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    #1;
    chk("mid_rst_fs_valid", 128'(fs_valid), 128'(1'b0));
    chk("mid_rst_to_ds_valid", 128'(fs_to_ds_valid), 128'(1'b0));
    chk("mid_rst_allowin", 128'(fs_allowin), 128'(1'b1));
    resetn = 1'b1;
    drive(6'b110010, 32'hbfc00024, 32'h0);
    @(negedge clk);
    drive(6'b000011, 32'h0, 32'h77777777);
    #1;
    chk("post_rst_to_ds_valid", 128'(fs_to_ds_valid), 128'(1'b1));
    chk("post_rst_inst", 128'(fs_to_ds_bus.inst), 128'(32'h77777777));

    // random traffic
    @(negedge clk);
    resetn = 1'b0;
    drive(6'b0, 32'h0, 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    q.delete();
    live = 0; have = 0; pend = 0;
    m_inst = '0; m_pkt = '0; rpkt = '0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (!pend && $urandom_range(0, 2) == 0) begin
        pend = 1;
        rpkt = '0;
        rpkt.valid = 1'b1;
        rpkt.br_op = 1'($urandom_range(0, 1));
        rpkt.pc = $urandom;
        if ($urandom_range(0, 7) == 0) begin
          rpkt.exception = adel(rpkt.pc);
          rpkt.exception.bd = 1'($urandom_range(0, 1));
        end else begin
          rpkt.addr_acked = 1'b1;
        end
      end
      pfs = pend ? rpkt : '0;
      ds_allowin = ($urandom_range(0, 3) != 0);
      inst_data_ok = (q.size() > 0) && ($urandom_range(0, 1) == 1);
      inst_rdata = $urandom;
      junk = q.size() - int'(inst_data_ok) + int'(pfs.addr_acked);
      pfl = '0;
      if (junk <= 3 && $urandom_range(0, 11) == 0) begin
        case ($urandom_range(0, 2))
          0: pfl.ex = 1'b1;
          1: pfl.eret = 1'b1;
          default: pfl.tlb_op = 1'b1;
        endcase
      end
      pfl.tlb_refill = 1'($urandom_range(0, 1));
      #1;
      f = pfl.ex | pfl.eret | pfl.tlb_op;
      arrive = inst_data_ok && q[0];
      ready = live && (m_pkt.exception.ex || have || arrive);
      e_allow = !live || (ready && ds_allowin);
      e_out = ready && !f;
      chk($sformatf("r%0d_allowin", c), 128'(fs_allowin), 128'(e_allow));
      chk($sformatf("r%0d_fs_valid", c), 128'(fs_valid), 128'(live));
      chk($sformatf("r%0d_to_ds_valid", c), 128'(fs_to_ds_valid), 128'(e_out));
      if (e_out) begin
        e_bus = '{pc: m_pkt.pc,
                  inst: m_pkt.exception.ex ? 32'h0 : (have ? m_inst : inst_rdata),
                  br_op: m_pkt.br_op, exception: m_pkt.exception};
        chk($sformatf("r%0d_bus", c), 128'(fs_to_ds_bus), 128'(e_bus));
      end
      if (inst_data_ok) void'(q.pop_front());
      if (f) begin
        foreach (q[i]) q[i] = 1'b0;
        if (pfs.addr_acked) q.push_back(1'b0);
        live = 0; have = 0; pend = 0;
      end else begin
        if (e_out && ds_allowin) begin
          live = 0; have = 0;
        end else if (arrive) begin
          have = 1; m_inst = inst_rdata;
        end
        if (e_allow && pfs.valid) begin
          live = 1; have = 0; pend = 0;
          m_pkt = pfs;
          if (pfs.addr_acked) q.push_back(1'b1);
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
Instruction-fetch stage of the 5-stage MIPS pipeline, directly downstream of pre-IF.
- Accepts the PC/exception packet that pre-IF hands over once the inst_sram address phase is accepted.
- Waits for the matching inst_sram data phase (data_ok) and holds the instruction word in a one-entry buffer while ID stalls.
- Forwards {pc, inst, br_op, exception} to ID.
- Discards in-flight responses belonging to flushed instructions, so a late data_ok never reaches ID.

Parameters:
DISCARD_W, 2, width of the stale-response discard counter (max 3 outstanding stale responses)

Ports:
clk  in  1  clock, all state updates on rising edge
resetn  in  1  synchronous, active-low reset
pfs_to_fs_bus  in  75  pfs_to_fs_bus_t {valid, addr_acked, br_op, pc[31:0], exception_t[39:0]}
fs_allowin  out  1  IF can accept a pre-IF packet this cycle
fs_valid  out  1  IF holds a live instruction
ds_allowin  in  1  ID can accept
fs_to_ds_valid  out  1  packet to ID valid
fs_to_ds_bus  out  105  fs_to_ds_bus_t {pc[31:0], inst[31:0], br_op, exception_t}
pipeline_flush  in  pipeline_flush_t  {ex, eret, tlb_op, tlb_refill}; flush = ex|eret|tlb_op
inst_data_ok  in  1  inst_sram data phase valid
inst_rdata  in  32  inst_sram read data

Behaviour:
Reset (resetn=0 at posedge):
- fs_valid, inst_buf_valid, req_pending, discard_cnt all go to 0.
- Consequently fs_to_ds_valid=0 and fs_allowin=1.

Latch (fs_allowin & pfs_to_fs_bus.valid & !flush):
- fs_valid<=1.
- Capture pc, br_op and exception.
- req_pending<=addr_acked.
- inst_buf_valid<=0.

Handshake:
- stale = (discard_cnt!=0).
- fs_ready_go = exception.ex | inst_buf_valid | (req_pending & inst_data_ok & !stale).
- fs_allowin = !fs_valid | (fs_ready_go & ds_allowin).
- fs_to_ds_valid = fs_valid & fs_ready_go & !flush.

Instruction select:
- inst = inst_buf_valid ? inst_buf : inst_rdata.
- Zero-latency pass-through: the instruction leaves IF in the same cycle data_ok arrives if ds_allowin=1.
- When exception.ex=1, inst=32'h0 and no request is outstanding.

Buffering:
- Condition: fs_valid & req_pending & inst_data_ok & !stale & !ds_allowin & !flush.
- Action: inst_buf<=inst_rdata, inst_buf_valid<=1, req_pending<=0.
- Buffer is cleared when the packet is accepted by ID or on flush.

Data_ok without a live request:
- If inst_data_ok arrives while stale=0 and req_pending=0, it is a protocol error. Flag it with an assertion and ignore the response.

Flush (pipeline_flush.ex|eret|tlb_op):
- fs_valid<=0 next cycle.
- fs_to_ds_valid is forced to 0 in the flush cycle.
- discard_cnt increments by the sum of:
  - +1 if fs_valid & req_pending & !(inst_data_ok & !stale): own response not yet returned.
  - +1 if pfs_to_fs_bus.addr_acked this cycle: pre-IF request already accepted by the bus.
- If inst_data_ok & stale in the same cycle, the counter also decrements by 1. Net update is applied in one step.
- If data_ok for the current instruction arrives in the flush cycle, it is consumed and dropped, with no increment for it.

Discard:
- While stale, each inst_data_ok decrements discard_cnt and is never forwarded or buffered.
- New packets may still be latched while stale. Their req_pending waits until the counter reaches 0, preserving in-order responses.

Saturation:
- discard_cnt must never exceed 2^DISCARD_W-1; assertion on overflow.
- Decrement at 0 cannot occur, because stale gates the decrement.

Reset mid-operation:
- All state is cleared and in-flight responses are not tracked.
- The bus is reset together with the core.

Decomposition:
Add to cpu_defs.svh (shared package):
- fs_to_ds_bus_t.
- pfs_to_fs_bus_t field order as listed above.
- A FLUSH_ANY helper for pipeline_flush_t.

Reuse exception_t and virt_t. One natural sub-module: if_inst_buffer, which holds the one-entry inst_buf plus valid and select mux. The discard counter stays inline.

Test Plan:
1. Basic flow: pc=0xbfc00000, addr_acked=1; data_ok=1 next cycle with rdata=0x24080001, ds_allowin=1 -> fs_to_ds_valid=1 that cycle with inst=0x24080001, pc=0xbfc00000.
2. ID stall: data_ok with rdata=0x8c090004 while ds_allowin=0 for 3 cycles -> inst_buf_valid=1, fs_allowin=0. ds_allowin=1 -> inst=0x8c090004 issued once, buffer cleared.
3. Flush with own request pending plus pre-IF addr_acked in the same cycle -> discard_cnt=2. The next two data_ok (rdata 0xdead0001, 0xdead0002) are dropped. The third (0x00000000 at 0xbfc00380) is forwarded.
4. Address error: exception.ex=1, exccode=ADEL, pc=0xbfc00002, addr_acked=0 -> fs_to_ds_valid=1 immediately, inst=0, badvaddr=0xbfc00002. No data_ok is consumed.
5. Flush in the same cycle as data_ok for the current instruction -> fs_to_ds_valid=0, discard_cnt stays 0, next packet proceeds normally.
6. resetn=0 asserted mid-stall with a buffered instruction -> after next posedge fs_valid=0, fs_to_ds_valid=0, fs_allowin=1, discard_cnt=0.
